// File: rtl/aib_pkg.sv
// aib_pkg: shared state encoding and helpers for the AIB link receive controller
package aib_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_WAIT_RSTN = 3'd1,
        ST_WAIT_CLK  = 3'd2,
        ST_WAIT_RDY  = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_ERROR     = 3'd5
    } aib_state_e;

    function automatic logic [7:0] deb_thresh(input logic [7:0] cyc);
        return (cyc == 8'd0) ? 8'd1 : cyc;
    endfunction

endpackage

// File: rtl/aib_sync_debounce.sv
// aib_sync_debounce: multi-flop synchronizer followed by a run-length level debouncer
module aib_sync_debounce
    import aib_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_async,
    input  logic [7:0] c_debounce_cyc,
    output logic       o_level
);

    logic [SyncStages-1:0] sync_q;
    logic [7:0]            cnt_q, cnt_d;
    logic                  lvl_q, lvl_d;
    logic                  sync_lvl, differ, hit;

    assign sync_lvl = sync_q[SyncStages-1];
    assign differ   = sync_lvl != lvl_q;
    assign hit      = ({1'b0, cnt_q} + 9'd1) >= {1'b0, deb_thresh(c_debounce_cyc)};
    assign o_level  = lvl_q;

    // extend the disagreement run, or flip the level once the run is long enough
    always_comb begin
        cnt_d = (differ && !hit) ? cnt_q + 8'd1 : 8'd0;
        lvl_d = (differ && hit) ? sync_lvl : lvl_q;
    end

    // synchronizer chain and debounce state
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], i_async};
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end

endmodule

// File: rtl/aib_link_rx_ctrl.sv
// aib_link_rx_ctrl: far-side sideband qualification and link bring-up state machine
module aib_link_rx_ctrl
    import aib_pkg::*;
#(
    parameter int SyncStages = 2,
    parameter int ClkActWin  = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        c_link_en,
    input  logic [7:0]  c_debounce_cyc,
    input  logic [15:0] c_timeout_cyc,
    input  logic        i_err_clr,
    input  logic        i_fs_adapter_rstn,
    input  logic        i_fs_mac_rdy,
    input  logic        i_fs_fwd_clk,
    output logic        o_fs_adapter_rstn,
    output logic        o_fs_mac_rdy,
    output logic        o_fwd_clk_alive,
    output logic        o_link_up,
    output logic        o_link_err,
    output logic [2:0]  o_state
);

    localparam int WW = $clog2(ClkActWin);

    aib_state_e            state_q, state_d;
    logic [SyncStages-1:0] fclk_q;
    logic                  fclk_prev_q, fclk_edge, win_end;
    logic [WW-1:0]         win_q;
    logic [1:0]            ecnt_q, ecnt_n;
    logic                  alive_q;
    logic [15:0]           tmo_q, tmo_d;
    logic                  tmo_hit, in_wait;
    logic                  err_q, err_d, up_q;
    logic                  rstn_lvl, rdy_lvl;

    aib_sync_debounce #(.SyncStages(SyncStages)) u_deb_rstn (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_async        (i_fs_adapter_rstn),
        .c_debounce_cyc (c_debounce_cyc),
        .o_level        (rstn_lvl)
    );

    aib_sync_debounce #(.SyncStages(SyncStages)) u_deb_rdy (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_async        (i_fs_mac_rdy),
        .c_debounce_cyc (c_debounce_cyc),
        .o_level        (rdy_lvl)
    );

    assign fclk_edge = fclk_q[SyncStages-1] ^ fclk_prev_q;
    assign ecnt_n    = (ecnt_q == 2'd3) ? 2'd3 : ecnt_q + {1'b0, fclk_edge};
    assign win_end   = win_q == WW'(ClkActWin - 1);

    // forwarded clock: synchronize, count edges per window, judge activity at window end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fclk_q      <= '0;
            fclk_prev_q <= 1'b0;
            win_q       <= '0;
            ecnt_q      <= '0;
            alive_q     <= 1'b0;
        end else begin
            fclk_q      <= {fclk_q[SyncStages-2:0], i_fs_fwd_clk};
            fclk_prev_q <= fclk_q[SyncStages-1];
            win_q       <= win_end ? '0 : win_q + WW'(1);
            ecnt_q      <= win_end ? 2'd0 : ecnt_n;
            alive_q     <= win_end ? ecnt_n[1] : alive_q;
        end
    end

    assign in_wait = (state_q == ST_WAIT_RSTN) || (state_q == ST_WAIT_CLK) || (state_q == ST_WAIT_RDY);
    assign tmo_hit = in_wait && (c_timeout_cyc != 16'd0) && (tmo_q + 16'd1 == c_timeout_cyc);

    // next state, shared wait timeout, sticky error with entry beating clear
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLED:  state_d = ST_WAIT_RSTN;
            ST_WAIT_RSTN: state_d = tmo_hit ? ST_ERROR : rstn_lvl ? ST_WAIT_CLK : state_q;
            ST_WAIT_CLK:  state_d = tmo_hit ? ST_ERROR : alive_q ? ST_WAIT_RDY : state_q;
            ST_WAIT_RDY:  state_d = tmo_hit ? ST_ERROR : rdy_lvl ? ST_LINK_UP : state_q;
            ST_LINK_UP:   state_d = (rstn_lvl && rdy_lvl && alive_q) ? state_q : ST_ERROR;
            ST_ERROR:     state_d = i_err_clr ? ST_DISABLED : state_q;
            default:      state_d = ST_DISABLED;
        endcase
        if (!c_link_en) state_d = ST_DISABLED;
        tmo_d = (state_q == ST_DISABLED) ? 16'd0 : in_wait ? tmo_q + 16'd1 : tmo_q;
        err_d = (state_d == ST_ERROR && state_q != ST_ERROR) ? 1'b1 : i_err_clr ? 1'b0 : err_q;
    end

    // controller state and registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_DISABLED;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            up_q    <= state_d == ST_LINK_UP;
        end
    end

    assign o_fs_adapter_rstn = rstn_lvl;
    assign o_fs_mac_rdy      = rdy_lvl;
    assign o_fwd_clk_alive   = alive_q;
    assign o_link_up         = up_q;
    assign o_link_err        = err_q;
    assign o_state           = state_q;

endmodule

// File: tb/tb_aib_link_rx_ctrl.sv
// tb_aib_link_rx_ctrl: randomized and directed checks of link bring-up, debounce, timeout and loss
module tb_aib_link_rx_ctrl;

    localparam int SS  = 2;
    localparam int WIN = 16;

    logic        clk = 1'b0;
    logic        rstn, en, err_clr, fs_rstn, fs_rdy, fs_fwd;
    logic [7:0]  deb;
    logic [15:0] tmo;
    logic        o_fs_adapter_rstn, o_fs_mac_rdy, o_fwd_clk_alive, o_link_up, o_link_err;
    logic [2:0]  o_state;

    int   checks = 0;
    int   errors = 0;
    int   fwd_en = 0;
    int   fwd_half = 4;
    int   fcnt = 0;
    int   first;
    int   len_r, len_m;
    logic hr[$];
    logic hm[$];
    logic mr = 1'b0;
    logic mm = 1'b0;

    aib_link_rx_ctrl #(.SyncStages(SS), .ClkActWin(WIN)) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .c_link_en         (en),
        .c_debounce_cyc    (deb),
        .c_timeout_cyc     (tmo),
        .i_err_clr         (err_clr),
        .i_fs_adapter_rstn (fs_rstn),
        .i_fs_mac_rdy      (fs_rdy),
        .i_fs_fwd_clk      (fs_fwd),
        .o_fs_adapter_rstn (o_fs_adapter_rstn),
        .o_fs_mac_rdy      (o_fs_mac_rdy),
        .o_fwd_clk_alive   (o_fwd_clk_alive),
        .o_link_up         (o_link_up),
        .o_link_err        (o_link_err),
        .o_state           (o_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fwd_en != 0) begin
            if (fcnt >= fwd_half - 1) begin
                fcnt = 0;
                fs_fwd = ~fs_fwd;
            end else begin
                fcnt = fcnt + 1;
            end
        end else begin
            fcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // true when every raw sample that reached the debouncer in the last n cycles disagrees with lvl
    function automatic bit win_diff(input bit sel, input int t, input int n, input logic lvl);
        logic v;
        for (int i = t - SS - n + 1; i <= t - SS; i++) begin
            v = (i < 0) ? 1'b0 : (sel ? hm[i] : hr[i]);
            if (v == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        int n, t;
        n = (deb == 8'd0) ? 1 : int'(deb);
        hr.push_back(rstn ? fs_rstn : 1'b0);
        hm.push_back(rstn ? fs_rdy : 1'b0);
        t = hr.size() - 1;
        if (!rstn) begin
            mr = 1'b0;
            mm = 1'b0;
        end else begin
            if (win_diff(1'b0, t, n, mr)) mr = ~mr;
            if (win_diff(1'b1, t, n, mm)) mm = ~mm;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("deb_adapter_rstn", o_fs_adapter_rstn, mr);
        check("deb_mac_rdy", o_fs_mac_rdy, mm);
        check("link_up_only_in_link_up", o_link_up, o_state == 3'd4);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target, input int bound);
        int n = 0;
        while (o_state !== target && n < bound) begin
            tick();
            n++;
        end
        check(tag, o_state, target);
    endtask

    initial begin
        rstn = 0; en = 0; deb = 8'd4; tmo = 16'd0; err_clr = 0;
        fs_rstn = 0; fs_rdy = 0; fs_fwd = 0;
        repeat (5) tick();
        check("rst_state", o_state, 3'd0);
        check("rst_link_up", o_link_up, 1'b0);
        check("rst_link_err", o_link_err, 1'b0);
        check("rst_alive", o_fwd_clk_alive, 1'b0);
        rstn = 1;
        repeat (3) tick();

        for (int it = 0; it < 20; it++) begin
            deb = (it == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            len_r = $urandom_range(1, 10);
            len_m = $urandom_range(1, 10);
            tick();
            for (int k = 0; k < 10; k++) begin
                fs_rstn = k < len_r;
                fs_rdy  = k < len_m;
                tick();
            end
            fs_rstn = 0;
            fs_rdy  = 0;
            repeat (14) tick();
        end
        check("disabled_idle_state", o_state, 3'd0);
        check("disabled_idle_alive", o_fwd_clk_alive, 1'b0);

        deb = 8'd4; tmo = 16'd1000;
        tick();
        en = 1;
        tick();
        check("enter_wait_rstn", o_state, 3'd1);
        fs_rstn = 1;
        repeat (3) tick();
        fs_rstn = 0;
        repeat (12) tick();
        check("glitch_state", o_state, 3'd1);
        check("glitch_level", o_fs_adapter_rstn, 1'b0);
        fs_rstn = 1;
        wait_state("to_wait_clk", 3'd2, 12);
        fwd_half = $urandom_range(3, 4);
        fwd_en = 1;
        wait_state("to_wait_rdy", 3'd3, 2 * WIN + SS + 6);
        check("bringup_alive", o_fwd_clk_alive, 1'b1);
        fs_rdy = 1;
        wait_state("to_link_up", 3'd4, 12);
        tick();
        check("bringup_link_up", o_link_up, 1'b1);
        check("bringup_no_err", o_link_err, 1'b0);
        repeat (50) tick();
        check("link_up_holds", o_state, 3'd4);

        fwd_en = 0;
        wait_state("loss_to_error", 3'd5, 2 * WIN + SS + 1);
        check("loss_err", o_link_err, 1'b1);
        check("loss_link_down", o_link_up, 1'b0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("errclr_state", o_state, 3'd0);
        check("errclr_err", o_link_err, 1'b0);
        en = 0; fs_rstn = 0; fs_rdy = 0;
        repeat (40) tick();
        check("idle_alive_cleared", o_fwd_clk_alive, 1'b0);

        tmo = 16'd50;
        tick();
        en = 1;
        tick();
        check("tmo_entry", o_state, 3'd1);
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (first < 0 && o_state == 3'd5) first = k;
        end
        check("timeout_cycle", 16'(first), 16'd50);
        check("timeout_err", o_link_err, 1'b1);

        tmo = 16'd0; en = 0;
        tick();
        check("disable_state", o_state, 3'd0);
        check("disable_keeps_err", o_link_err, 1'b1);
        en = 1;
        repeat (300) tick();
        check("no_timeout_state", o_state, 3'd1);
        check("no_timeout_err", o_link_err, 1'b1);
        fs_rstn = 1;
        fwd_half = $urandom_range(2, 4);
        fwd_en = 1;
        wait_state("prio_wait_clk", 3'd2, 12);
        wait_state("prio_wait_rdy", 3'd3, 2 * WIN + SS + 6);
        en = 0; err_clr = 1;
        tick();
        err_clr = 0;
        check("prio_state", o_state, 3'd0);
        check("prio_err", o_link_err, 1'b0);

        fs_rdy = 1; en = 1;
        wait_state("relink_up", 3'd4, 30);
        tick();
        check("relink_link_up", o_link_up, 1'b1);
        rstn = 0;
        #1;
        check("async_rst_state", o_state, 3'd0);
        check("async_rst_link_up", o_link_up, 1'b0);
        check("async_rst_err", o_link_err, 1'b0);
        check("async_rst_alive", o_fwd_clk_alive, 1'b0);
        check("async_rst_adapter", o_fs_adapter_rstn, 1'b0);
        check("async_rst_mac", o_fs_mac_rdy, 1'b0);
        en = 0; fs_rstn = 0; fs_rdy = 0; fwd_en = 0;
        repeat (5) tick();
        rstn = 1;
        repeat (3) tick();
        check("post_rst_state", o_state, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aib_link_rx_ctrl.md
AIB_LINK_RX_CTRL -- requirements
Module: aib_link_rx_ctrl

Interface
REQ-001 SHALL have parameter SyncStages, default 2, synchronizer depth for each async far-side input (minimum 2).
REQ-002 SHALL have parameter ClkActWin, default 16, length in i_clk cycles of the forwarded-clock activity window (minimum 4).
REQ-003 SHALL have port i_clk, input, 1, sole block clock; all state is clocked on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port c_link_en, input, 1, link bring-up enable.
REQ-006 SHALL have port c_debounce_cyc, input, 8, stable cycles needed to accept a new sideband level; 0 is treated as 1.
REQ-007 SHALL have port c_timeout_cyc, input, 16, bring-up timeout in cycles; 0 disables the timeout.
REQ-008 SHALL have port i_err_clr, input, 1, single-cycle pulse that clears the error condition.
REQ-009 SHALL have port i_fs_adapter_rstn, input, 1, far-side adapter reset taken from the async receive path.
REQ-010 SHALL have port i_fs_mac_rdy, input, 1, far-side MAC ready taken from the async receive path.
REQ-011 SHALL have port i_fs_fwd_clk, input, 1, far-side forwarded div2 clock bump, treated as async data.
REQ-012 SHALL have outputs o_fs_adapter_rstn, o_fs_mac_rdy, o_fwd_clk_alive, o_link_up and o_link_err, each 1 bit: the debounced levels, clock-alive, link-up and sticky error.
REQ-013 SHALL have output o_state, 3 bits, current FSM state encoding.

Function
REQ-014 SHALL pass each async input through SyncStages flops before any other logic uses it.
REQ-015 SHALL update a debounced level only after the synchronized value has differed from it for max(c_debounce_cyc,1) consecutive cycles; any cycle of agreement resets the count.
REQ-016 SHALL detect edges as the XOR of the synchronized fwd clk and its previous value, count edges (saturating at 3) in each ClkActWin-cycle window, and set o_fwd_clk_alive at window end if the count is >=2, else clear it.
REQ-017 SHALL guarantee correct alive detection only for fwd clk frequency <= i_clk/4.
REQ-018 SHALL implement FSM states DISABLED=0, WAIT_RSTN=1, WAIT_CLK=2, WAIT_RDY=3, LINK_UP=4, ERROR=5.
REQ-019 SHALL, in DISABLED, move to WAIT_RSTN when c_link_en=1 and clear the timeout counter.
REQ-020 SHALL move WAIT_RSTN->WAIT_CLK when o_fs_adapter_rstn=1, WAIT_CLK->WAIT_RDY when o_fwd_clk_alive=1, and WAIT_RDY->LINK_UP when o_fs_mac_rdy=1.
REQ-021 SHALL run one 16-bit timeout counter across all WAIT_* states, reset on entry to WAIT_RSTN, and move to ERROR when it equals a nonzero c_timeout_cyc.
REQ-022 SHALL move LINK_UP->ERROR when any of o_fs_adapter_rstn, o_fs_mac_rdy or o_fwd_clk_alive is 0.
REQ-023 SHALL set o_link_err on every entry to ERROR; it stays set until i_err_clr.
REQ-024 SHALL, in ERROR, move to DISABLED on i_err_clr=1 and clear o_link_err in the same cycle.
REQ-025 SHALL give c_link_en=0 top priority: any state goes to DISABLED next cycle and o_link_err is retained.
REQ-026 SHALL, on i_err_clr outside ERROR, only clear o_link_err; if an error entry coincides with i_err_clr, the error wins.
REQ-027 SHALL drive o_link_up=1 only in LINK_UP; it is registered and asserts the cycle after the transition.

Reset
REQ-028 SHALL, on i_rstn=0, asynchronously clear all sync flops, debounce and window counters, the timeout counter and all outputs, and force the state to DISABLED.
REQ-029 SHALL release reset synchronously relative to i_clk; the upstream reset synchronizer guarantees this.

Structure
REQ-030 SHALL place the state enum typedef and its 3-bit encoding in the shared package aib_pkg.
REQ-031 SHALL implement the synchronizer plus debounce as sub-module aib_sync_debounce, instantiated for adapter_rstn and mac_rdy; fwd clk uses the synchronizer only.

Verification
REQ-032 SHALL cover normal bring-up: debounce=4, timeout=1000, rstn rise, then a clk/8 fwd clock, then mac_rdy -> states 1->2->3->4; o_link_up=1 and o_link_err=0.
REQ-033 SHALL cover a glitch: debounce=4, 3-cycle pulse on i_fs_adapter_rstn -> o_fs_adapter_rstn stays 0 and the state stays WAIT_RSTN.
REQ-034 SHALL cover timeout: timeout=50 and no far-side activity -> ERROR at cycle 50 after WAIT_RSTN entry, o_link_err=1; with timeout=0 the block waits indefinitely.
REQ-035 SHALL cover link loss: in LINK_UP, stop the fwd clk -> ERROR within 2*ClkActWin+SyncStages+1 cycles; an i_err_clr pulse -> DISABLED and o_link_err=0.
REQ-036 SHALL cover priority: c_link_en=0 together with i_err_clr in WAIT_RDY -> DISABLED, o_link_err cleared; assert i_rstn mid-LINK_UP -> all outputs 0 immediately.
